// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NCH SRAM-like request channels onto one master port.
// Accepted requests are tracked in an in-order ID FIFO, so each master response
// is steered back to the channel that issued the matching request.
// Request and response paths are purely combinational (zero added latency).
// Optional feature macro: ARB_RR_EN selects round-robin arbitration. When the
// macro is undefined, arbitration is fixed priority with channel 0 highest.
module sram_like_arbiter #(
    parameter int NCH         = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NCH-1:0]           ch_req,
    input  logic [NCH-1:0]           ch_wr,
    input  logic [2*NCH-1:0]         ch_size,
    input  logic [ADDR_W*NCH-1:0]    ch_addr,
    input  logic [DATA_W*NCH-1:0]    ch_wdata,
    output logic [NCH-1:0]           ch_addr_ok,
    output logic [NCH-1:0]           ch_data_ok,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     m_req,
    output logic                     m_wr,
    output logic [1:0]               m_size,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]        m_wdata,
    input  logic                     m_addr_ok,
    input  logic                     m_data_ok,
    input  logic [DATA_W-1:0]        m_rdata,
    output logic                     resp_err
);

    localparam int ID_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    // Grant bookkeeping: gnt_q holds the channel that stalled on the master.
    logic [ID_W-1:0]  gnt_q, gnt_d;
    logic             lock_q, lock_d;
    logic [ID_W-1:0]  pick_s;
    logic [ID_W-1:0]  gnt_s;

    // In-order ID FIFO of channels waiting for their response.
    logic [ID_W-1:0]  fifo_q [OUTSTANDING];
    logic [ID_W-1:0]  fifo_d [OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_err_q, resp_err_d;

    logic             full_s;
    logic             empty_s;
    logic             m_req_s;
    logic             push_s;
    logic             pop_s;
    logic [ID_W-1:0]  head_s;

`ifdef ARB_RR_EN
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
`endif

    // Advance a FIFO pointer, wrapping at the configured depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTANDING - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

`ifdef ARB_RR_EN
    // Round-robin pick: first requesting channel at or after rr_ptr.
    always_comb begin
        int  idx;
        logic found;
        logic hit;
        pick_s = {ID_W{1'b0}};
        found  = 1'b0;
        idx    = 0;
        hit    = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx    = (int'(rr_ptr_q) + k) % NCH;
            hit    = !found && ch_req[idx];
            pick_s = hit ? ID_W'(idx) : pick_s;
            found  = found | hit;
        end
    end
`else
    // Fixed-priority pick: lowest-index requesting channel wins.
    always_comb begin
        pick_s = {ID_W{1'b0}};
        for (int k = NCH - 1; k >= 0; k--) begin
            pick_s = ch_req[k] ? ID_W'(k) : pick_s;
        end
    end
`endif

    // Grant, handshakes and master-side muxing; all combinational.
    always_comb begin
        gnt_s   = lock_q ? gnt_q : pick_s;
        full_s  = (cnt_q == CNT_W'(OUTSTANDING));
        empty_s = (cnt_q == {CNT_W{1'b0}});
        // Forced low in reset so nothing leaks out while the flops are cleared.
        m_req_s = resetn && ch_req[gnt_s] && !full_s;
        push_s  = m_req_s && m_addr_ok;
        pop_s   = resetn && m_data_ok && !empty_s;
        head_s  = fifo_q[rd_ptr_q];

        m_req      = m_req_s;
        m_wr       = 1'b0;
        m_size     = 2'b00;
        m_addr     = {ADDR_W{1'b0}};
        m_wdata    = {DATA_W{1'b0}};
        ch_addr_ok = {NCH{1'b0}};
        ch_data_ok = {NCH{1'b0}};
        ch_rdata   = m_rdata;
        for (int i = 0; i < NCH; i++) begin
            m_wr          = (gnt_s == ID_W'(i)) ? ch_wr[i]                      : m_wr;
            m_size        = (gnt_s == ID_W'(i)) ? ch_size[2*i +: 2]             : m_size;
            m_addr        = (gnt_s == ID_W'(i)) ? ch_addr[ADDR_W*i +: ADDR_W]   : m_addr;
            m_wdata       = (gnt_s == ID_W'(i)) ? ch_wdata[DATA_W*i +: DATA_W]  : m_wdata;
            ch_addr_ok[i] = push_s && (gnt_s == ID_W'(i));
            ch_data_ok[i] = pop_s && (head_s == ID_W'(i));
        end
        resp_err = resp_err_q;
    end

    // Next-state logic for the FIFO, lock, sticky error and RR pointer.
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        lock_d     = lock_q;
        gnt_d      = gnt_q;
        resp_err_d = resp_err_q | (m_data_ok && empty_s);

        if (push_s) begin
            fifo_d[wr_ptr_q] = gnt_s;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // A stalled request pins the grant; acceptance or a dropped request
        // releases it. Arbitration is frozen entirely while the FIFO is full.
        if (full_s) begin
            lock_d = lock_q;
            gnt_d  = gnt_q;
        end else if (m_req_s && !m_addr_ok) begin
            lock_d = 1'b1;
            gnt_d  = gnt_s;
        end else begin
            lock_d = 1'b0;
            gnt_d  = gnt_q;
        end

`ifdef ARB_RR_EN
        if (push_s) begin
            rr_ptr_d = (gnt_s == ID_W'(NCH - 1)) ? {ID_W{1'b0}} : gnt_s + ID_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
`endif
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                fifo_q[i] <= {ID_W{1'b0}};
            end
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            lock_q     <= 1'b0;
            gnt_q      <= {ID_W{1'b0}};
            resp_err_q <= 1'b0;
`ifdef ARB_RR_EN
            rr_ptr_q   <= {ID_W{1'b0}};
`endif
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            gnt_q      <= gnt_d;
            resp_err_q <= resp_err_d;
`ifdef ARB_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a queue-based reference.
module tb_sram_like_arbiter;

    localparam int NCH         = 2;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int OUTSTANDING = 2;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic [NCH-1:0]        ch_req;
    logic [NCH-1:0]        ch_wr;
    logic [2*NCH-1:0]      ch_size;
    logic [ADDR_W*NCH-1:0] ch_addr;
    logic [DATA_W*NCH-1:0] ch_wdata;
    logic [NCH-1:0]        ch_addr_ok;
    logic [NCH-1:0]        ch_data_ok;
    logic [DATA_W-1:0]     ch_rdata;
    logic                  m_req;
    logic                  m_wr;
    logic [1:0]            m_size;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic                  m_addr_ok;
    logic                  m_data_ok;
    logic [DATA_W-1:0]     m_rdata;
    logic                  resp_err;

    sram_like_arbiter #(
        .NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTSTANDING(OUTSTANDING)
    ) dut (
        .clk(clk), .resetn(resetn),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: outstanding channel IDs in issue order, stalled channel, RR start.
    int q[$];
    bit locked  = 1'b0;
    int lock_ch = 0;
    int rr      = 0;
    bit err     = 1'b0;

    // Snapshots of DUT outputs from the most recent cycle, for directed checks.
    logic [NCH-1:0]    obs_aok, obs_dok;
    logic              obs_mreq, obs_err;
    logic [ADDR_W-1:0] obs_maddr;
    logic [DATA_W-1:0] obs_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which channel should win when nothing is stalled.
    function automatic int pick(input logic [NCH-1:0] r);
`ifdef ARB_RR_EN
        for (int k = 0; k < NCH; k++) begin
            if (r[(rr + k) % NCH]) return (rr + k) % NCH;
        end
`else
        for (int c = 0; c < NCH; c++) begin
            if (r[c]) return c;
        end
`endif
        return 0;
    endfunction

    // One clock: compare outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        int g;
        bit full;
        bit emreq;
        logic [NCH-1:0] eaok;
        logic [NCH-1:0] edok;
        #2;
        if (!resetn) begin
            q.delete();
            locked = 1'b0;
            rr     = 0;
            err    = 1'b0;
        end
        g     = locked ? lock_ch : pick(ch_req);
        full  = (q.size() >= OUTSTANDING);
        emreq = resetn && ch_req[g] && !full;
        eaok  = '0;
        if (emreq && m_addr_ok) eaok[g] = 1'b1;
        edok  = '0;
        if (resetn && m_data_ok && q.size() > 0) edok[q[0]] = 1'b1;

        chk("m_req", m_req, emreq);
        chk("ch_addr_ok", ch_addr_ok, eaok);
        chk("ch_data_ok", ch_data_ok, edok);
        chk("resp_err", resp_err, err);
        if (emreq) begin
            chk("m_addr", m_addr, ch_addr[g*ADDR_W +: ADDR_W]);
            chk("m_wdata", m_wdata, ch_wdata[g*DATA_W +: DATA_W]);
            chk("m_wr", m_wr, ch_wr[g]);
            chk("m_size", m_size, ch_size[2*g +: 2]);
        end
        if (edok != '0) chk("ch_rdata", ch_rdata, m_rdata);

        obs_aok   = ch_addr_ok;
        obs_dok   = ch_data_ok;
        obs_mreq  = m_req;
        obs_err   = resp_err;
        obs_maddr = m_addr;
        obs_rdata = ch_rdata;

        @(posedge clk);
        if (resetn) begin
            if (m_data_ok) begin
                if (q.size() > 0) void'(q.pop_front());
                else err = 1'b1;
            end
            if (eaok != '0) begin
                q.push_back(g);
                rr = (g + 1) % NCH;
            end
            if (!full) begin
                if (emreq && !m_addr_ok) begin
                    locked  = 1'b1;
                    lock_ch = g;
                end else begin
                    locked = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        ch_req    = '0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
    endtask

    initial begin
        logic [NCH-1:0] exp_arb;
        resetn    = 1'b0;
        ch_req    = '0;
        ch_wr     = '0;
        ch_size   = '0;
        ch_addr   = '0;
        ch_wdata  = '0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = '0;

        // Reset: outputs quiet even with active inputs.
        ch_req = 2'b11; m_addr_ok = 1'b1; m_data_ok = 1'b1;
        cycle();
        chk("rst_mreq", obs_mreq, 1'b0);
        chk("rst_aok", obs_aok, 2'b00);
        chk("rst_dok", obs_dok, 2'b00);
        chk("rst_err", obs_err, 1'b0);
        cycle();
        resetn = 1'b1;
        idle();
        cycle();

        // Single read on ch1, answered three cycles later.
        ch_req = 2'b10; ch_wr = 2'b00; ch_size = 4'b1000;
        ch_addr[ADDR_W +: ADDR_W] = 32'h0000_1000;
        m_addr_ok = 1'b1;
        cycle();
        chk("sr_aok", obs_aok, 2'b10);
        chk("sr_addr", obs_maddr, 32'h0000_1000);
        idle();
        cycle();
        chk("sr_dok_wait", obs_dok, 2'b00);
        cycle();
        m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("sr_dok", obs_dok, 2'b10);
        chk("sr_rdata", obs_rdata, 32'hDEAD_BEEF);
        idle();

        // Stall lock: ch1 stalls, ch0 arrives, ch1 keeps the master.
        ch_addr[ADDR_W +: ADDR_W] = 32'h0000_2000;
        ch_addr[0 +: ADDR_W]      = 32'h0000_3000;
        ch_req = 2'b10;
        cycle();
        ch_req = 2'b11;
        cycle();
        chk("sl_addr_stall", obs_maddr, 32'h0000_2000);
        m_addr_ok = 1'b1;
        cycle();
        chk("sl_aok1", obs_aok, 2'b10);
        chk("sl_addr_acc", obs_maddr, 32'h0000_2000);
        ch_req = 2'b01;
        cycle();
        chk("sl_aok0", obs_aok, 2'b01);
        idle();
        m_data_ok = 1'b1; m_rdata = 32'h1111_1111;
        cycle();
        chk("sl_dok_a", obs_dok, 2'b10);
        cycle();
        chk("sl_dok_b", obs_dok, 2'b01);
        idle();

        // FIFO full: third accept blocked until a response frees a slot.
        m_addr_ok = 1'b1;
        ch_req = 2'b01; cycle();
        ch_req = 2'b10; cycle();
        ch_req = 2'b01; cycle();
        chk("ff_mreq_full", obs_mreq, 1'b0);
        m_data_ok = 1'b1; m_rdata = 32'h2222_2222;
        cycle();
        chk("ff_mreq_still", obs_mreq, 1'b0);
        chk("ff_dok0", obs_dok, 2'b01);
        m_data_ok = 1'b0;
        cycle();
        chk("ff_mreq_back", obs_mreq, 1'b1);
        chk("ff_aok", obs_aok, 2'b01);
        idle();
        m_data_ok = 1'b1;
        cycle();
        chk("ff_dok1", obs_dok, 2'b10);
        cycle();
        chk("ff_dok2", obs_dok, 2'b01);
        idle();

        // Push and pop in one cycle at count 1.
        ch_req = 2'b01; m_addr_ok = 1'b1;
        cycle();
        ch_req = 2'b10; m_data_ok = 1'b1; m_rdata = 32'h3333_3333;
        cycle();
        chk("pp_dok", obs_dok, 2'b01);
        chk("pp_aok", obs_aok, 2'b10);
        idle();
        m_data_ok = 1'b1;
        cycle();
        chk("pp_dok_next", obs_dok, 2'b10);
        idle();

        // Spurious response sets a sticky error; reset clears it.
        m_data_ok = 1'b1;
        cycle();
        chk("sp_dok", obs_dok, 2'b00);
        idle();
        cycle();
        chk("sp_err", obs_err, 1'b1);
        cycle();
        chk("sp_err_sticky", obs_err, 1'b1);
        resetn = 1'b0;
        cycle();
        chk("sp_err_clr", obs_err, 1'b0);
        resetn = 1'b1;
        cycle();

        // Arbitration mode with both channels always requesting.
        ch_req = 2'b11; m_addr_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_data_ok = (i != 0);
            cycle();
`ifdef ARB_RR_EN
            exp_arb = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_arb = 2'b01;
`endif
            chk("arb_grant", obs_aok, exp_arb);
        end
        idle();
        m_data_ok = 1'b1;
        cycle();
        idle();

        // Randomized traffic, including dropped stalled requests and resets.
        for (int i = 0; i < 400; i++) begin
            resetn    = ($urandom_range(0, 99) != 0);
            ch_req    = NCH'($urandom);
            ch_wr     = NCH'($urandom);
            ch_size   = (2*NCH)'($urandom);
            ch_addr   = {$urandom, $urandom};
            ch_wdata  = {$urandom, $urandom};
            m_addr_ok = 1'($urandom_range(0, 1));
            m_data_ok = ($urandom_range(0, 2) == 0);
            m_rdata   = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
